// File: rtl/ts_cc_multi_checker.sv
// Multi-PID MPEG-2 TS continuity-counter checker: parses TS headers, learns PIDs
// into a NUM_CH-entry table and counts CC errors per channel and in total.
module ts_cc_multi_checker #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic              sync,
  input  logic [7:0]        data,
  input  logic              clr_counters,
  input  logic              flush_table,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_err,
  output logic [12:0]       rd_pid,
  output logic              rd_used,
  output logic [CNT_W-1:0]  total_err,
  output logic [CNT_W-1:0]  unmapped_cnt,
  output logic              table_full,
  output logic              cc_error,
  output logic [12:0]       err_pid
);

  typedef enum logic [2:0] {IDLE, H1, H2, H3, H4, H5, EVAL} state_t;

  state_t              state_q, state_d;
  logic                tei_q, tei_d;
  logic [12:0]         pid_q, pid_d;
  logic [1:0]          afc_q, afc_d;
  logic [3:0]          cc_q, cc_d;
  logic [7:0]          af_len_q, af_len_d;
  logic                disc_q, disc_d;

  logic [NUM_CH-1:0]   used_q, used_d;
  logic [NUM_CH-1:0]   dup_q, dup_d;
  logic [12:0]         tab_pid_q [NUM_CH];
  logic [12:0]         tab_pid_d [NUM_CH];
  logic [3:0]          tab_cc_q  [NUM_CH];
  logic [3:0]          tab_cc_d  [NUM_CH];
  logic [CNT_W-1:0]    err_cnt_q [NUM_CH];
  logic [CNT_W-1:0]    err_cnt_d [NUM_CH];

  logic [CNT_W-1:0]    total_err_q, total_err_d;
  logic [CNT_W-1:0]    unmapped_q, unmapped_d;
  logic [CNT_W-1:0]    rd_err_q, rd_err_d;
  logic [12:0]         rd_pid_q, rd_pid_d;
  logic                rd_used_q, rd_used_d;
  logic                cc_error_q, cc_error_d;
  logic [12:0]         err_pid_q, err_pid_d;

  logic                start, skip, hit, free, err;
  logic [CH_W-1:0]     hit_idx, free_idx;
  logic [3:0]          last_cc;
  logic                last_dup;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    tei_d       = tei_q;
    pid_d       = pid_q;
    afc_d       = afc_q;
    cc_d        = cc_q;
    af_len_d    = af_len_q;
    disc_d      = disc_q;
    used_d      = used_q;
    dup_d       = dup_q;
    tab_pid_d   = tab_pid_q;
    tab_cc_d    = tab_cc_q;
    err_cnt_d   = err_cnt_q;
    total_err_d = total_err_q;
    unmapped_d  = unmapped_q;
    err_pid_d   = err_pid_q;
    cc_error_d  = 1'b0;
    err         = 1'b0;
    last_cc     = '0;
    last_dup    = 1'b0;

    start = valid && sync && (data == 8'h47);
    skip  = tei_q || (pid_q == 13'h1FFF) || (afc_q == 2'b00);

    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (used_q[i] && (tab_pid_q[i] == pid_q) && !hit) begin
        hit     = 1'b1;
        hit_idx = CH_W'(i);
      end
      if (!used_q[i] && !free) begin
        free     = 1'b1;
        free_idx = CH_W'(i);
      end
    end

    case (state_q)
      IDLE: if (start) state_d = H1;
      H1: begin
        if (start) state_d = H1;
        else if (valid) begin
          tei_d       = data[7];
          pid_d[12:8] = data[4:0];
          state_d     = H2;
        end
      end
      H2: begin
        if (start) state_d = H1;
        else if (valid) begin
          pid_d[7:0] = data;
          state_d    = H3;
        end
      end
      H3: begin
        if (start) state_d = H1;
        else if (valid) begin
          afc_d   = data[5:4];
          cc_d    = data[3:0];
          state_d = H4;
        end
      end
      H4: begin
        if (start) state_d = H1;
        else if (valid) begin
          af_len_d = data;
          state_d  = H5;
        end
      end
      H5: begin
        if (start) state_d = H1;
        else if (valid) begin
          disc_d  = afc_q[1] && (af_len_q != 8'd0) && data[7];
          state_d = EVAL;
        end
      end
      EVAL: begin
        // The finished header is evaluated even if a new sync arrives this cycle.
        state_d = start ? H1 : IDLE;
        if (!skip) begin
          if (hit) begin
            last_cc  = tab_cc_q[hit_idx];
            last_dup = dup_q[hit_idx];
            if (disc_q) begin
              tab_cc_d[hit_idx] = cc_q;
              dup_d[hit_idx]    = 1'b0;
            end else if (afc_q == 2'b10) begin
              err               = (cc_q != last_cc);
              tab_cc_d[hit_idx] = cc_q;
            end else if (cc_q == last_cc + 4'd1) begin
              tab_cc_d[hit_idx] = cc_q;
              dup_d[hit_idx]    = 1'b0;
            end else if ((cc_q == last_cc) && !last_dup) begin
              dup_d[hit_idx] = 1'b1;
            end else begin
              err               = 1'b1;
              tab_cc_d[hit_idx] = cc_q;
              dup_d[hit_idx]    = 1'b0;
            end
            if (err) begin
              err_cnt_d[hit_idx] = sat_inc(err_cnt_q[hit_idx]);
              total_err_d        = sat_inc(total_err_q);
              err_pid_d          = pid_q;
              cc_error_d         = 1'b1;
            end
          end else if (free) begin
            used_d[free_idx]    = 1'b1;
            tab_pid_d[free_idx] = pid_q;
            tab_cc_d[free_idx]  = cc_q;
            dup_d[free_idx]     = 1'b0;
          end else begin
            unmapped_d = sat_inc(unmapped_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_counters || flush_table) begin
      total_err_d = '0;
      unmapped_d  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) err_cnt_d[i] = '0;
    end
    if (flush_table) begin
      used_d  = '0;
      dup_d   = '0;
      state_d = IDLE;
    end

    rd_err_d  = '0;
    rd_pid_d  = '0;
    rd_used_d = 1'b0;
    if (int'(rd_ch) < NUM_CH) begin
      rd_err_d  = err_cnt_q[rd_ch];
      rd_pid_d  = tab_pid_q[rd_ch];
      rd_used_d = used_q[rd_ch];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tei_q       <= 1'b0;
      pid_q       <= '0;
      afc_q       <= '0;
      cc_q        <= '0;
      af_len_q    <= '0;
      disc_q      <= 1'b0;
      used_q      <= '0;
      dup_q       <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        tab_pid_q[i] <= '0;
        tab_cc_q[i]  <= '0;
        err_cnt_q[i] <= '0;
      end
      total_err_q <= '0;
      unmapped_q  <= '0;
      rd_err_q    <= '0;
      rd_pid_q    <= '0;
      rd_used_q   <= 1'b0;
      cc_error_q  <= 1'b0;
      err_pid_q   <= '0;
    end else begin
      state_q     <= state_d;
      tei_q       <= tei_d;
      pid_q       <= pid_d;
      afc_q       <= afc_d;
      cc_q        <= cc_d;
      af_len_q    <= af_len_d;
      disc_q      <= disc_d;
      used_q      <= used_d;
      dup_q       <= dup_d;
      tab_pid_q   <= tab_pid_d;
      tab_cc_q    <= tab_cc_d;
      err_cnt_q   <= err_cnt_d;
      total_err_q <= total_err_d;
      unmapped_q  <= unmapped_d;
      rd_err_q    <= rd_err_d;
      rd_pid_q    <= rd_pid_d;
      rd_used_q   <= rd_used_d;
      cc_error_q  <= cc_error_d;
      err_pid_q   <= err_pid_d;
    end
  end

  assign rd_err       = rd_err_q;
  assign rd_pid       = rd_pid_q;
  assign rd_used      = rd_used_q;
  assign total_err    = total_err_q;
  assign unmapped_cnt = unmapped_q;
  assign table_full   = &used_q;
  assign cc_error     = cc_error_q;
  assign err_pid      = err_pid_q;

endmodule

// File: tb/tb_ts_cc_multi_checker.sv
// Directed bench for ts_cc_multi_checker: a packet vector table plus hand-written
// sequences for clear, header restart, saturation, flush and mid-packet reset.
module tb_ts_cc_multi_checker;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              valid, sync;
  logic [7:0]        data;
  logic              clr_counters, flush_table;
  logic [1:0]        rd_ch;
  logic [CNT_W-1:0]  rd_err, total_err, unmapped_cnt;
  logic [12:0]       rd_pid, err_pid;
  logic              rd_used, table_full, cc_error;

  ts_cc_multi_checker #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .sync(sync), .data(data),
    .clr_counters(clr_counters), .flush_table(flush_table), .rd_ch(rd_ch),
    .rd_err(rd_err), .rd_pid(rd_pid), .rd_used(rd_used), .total_err(total_err),
    .unmapped_cnt(unmapped_cnt), .table_full(table_full), .cc_error(cc_error),
    .err_pid(err_pid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] pid;
    logic        tei;
    logic [1:0]  afc;
    logic [3:0]  cc;
    logic [7:0]  af_len;
    logic [7:0]  flag;
    logic        exp_err;
    int          exp_total;
    int          exp_unm;
    logic        exp_full;
    logic [12:0] exp_epid;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  function automatic void add(input logic [12:0] p, input logic t, input logic [1:0] a,
                              input logic [3:0] c, input logic [7:0] al, input logic [7:0] fl,
                              input logic e, input int tot, input int unm, input logic f,
                              input logic [12:0] ep);
    vec_t v;
    v.pid = p; v.tei = t; v.afc = a; v.cc = c; v.af_len = al; v.flag = fl;
    v.exp_err = e; v.exp_total = tot; v.exp_unm = unm; v.exp_full = f; v.exp_epid = ep;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic v, input logic s, input logic [7:0] d);
    valid = v; sync = s; data = d;
    @(posedge clk);
    #1;
  endtask

  // After the pad byte's edge the packet has been evaluated and cc_error is visible.
  task automatic send_pkt(input logic [12:0] pid, input logic tei, input logic [1:0] afc,
                          input logic [3:0] cc, input logic [7:0] af_len,
                          input logic [7:0] flag, input logic clr);
    put(1, 1, 8'h47);
    put(1, 0, {tei, 2'b00, pid[12:8]});
    put(1, 0, pid[7:0]);
    put(1, 0, {2'b00, afc, cc});
    put(1, 0, af_len);
    put(1, 0, flag);
    clr_counters = clr;
    put(1, 0, 8'hAA);
    clr_counters = 1'b0;
  endtask

  task automatic rd(input int ch);
    rd_ch = 2'(ch);
    put(0, 0, 8'h00);
  endtask

  initial begin
    reset_n = 1'b0; valid = 0; sync = 0; data = '0;
    clr_counters = 0; flush_table = 0; rd_ch = '0;

    for (int i = 0; i < 18; i++) add(13'h100, 0, 2'b01, 4'(i % 16), 0, 0, 0, 0, 0, 0, 13'h0);
    add(13'h100, 0, 2'b01, 4'd2,  0, 0,     0, 0, 0, 0, 13'h000);
    add(13'h100, 0, 2'b01, 4'd3,  0, 0,     0, 0, 0, 0, 13'h000);
    add(13'h100, 0, 2'b01, 4'd5,  0, 0,     1, 1, 0, 0, 13'h100);
    add(13'h100, 0, 2'b01, 4'd6,  0, 0,     0, 1, 0, 0, 13'h100);
    add(13'h200, 0, 2'b01, 4'd7,  0, 0,     0, 1, 0, 0, 13'h100);
    add(13'h200, 0, 2'b01, 4'd7,  0, 0,     0, 1, 0, 0, 13'h100);
    add(13'h200, 0, 2'b01, 4'd7,  0, 0,     1, 2, 0, 0, 13'h200);
    add(13'h200, 0, 2'b10, 4'd7,  1, 8'h00, 0, 2, 0, 0, 13'h200);
    add(13'h200, 0, 2'b10, 4'd8,  1, 8'h00, 1, 3, 0, 0, 13'h200);
    add(13'h300, 0, 2'b01, 4'd2,  0, 0,     0, 3, 0, 0, 13'h200);
    add(13'h300, 0, 2'b11, 4'd9,  1, 8'h80, 0, 3, 0, 0, 13'h200);
    add(13'h300, 0, 2'b01, 4'd10, 0, 0,     0, 3, 0, 0, 13'h200);
    add(13'h1FFF,0, 2'b01, 4'd0,  0, 0,     0, 3, 0, 0, 13'h200);
    add(13'h100, 1, 2'b01, 4'd0,  0, 0,     0, 3, 0, 0, 13'h200);
    add(13'h100, 0, 2'b00, 4'd0,  0, 0,     0, 3, 0, 0, 13'h200);
    add(13'h100, 0, 2'b01, 4'd7,  0, 0,     0, 3, 0, 0, 13'h200);
    add(13'h100, 0, 2'b01, 4'd12, 1, 8'h80, 1, 4, 0, 0, 13'h100);
    add(13'h400, 0, 2'b01, 4'd0,  0, 0,     0, 4, 0, 1, 13'h100);
    add(13'h500, 0, 2'b01, 4'd0,  0, 0,     0, 4, 1, 1, 13'h100);
    add(13'h500, 0, 2'b01, 4'd1,  0, 0,     0, 4, 2, 1, 13'h100);
    add(13'h1FFF,0, 2'b01, 4'd0,  0, 0,     0, 4, 2, 1, 13'h100);
    add(13'h300, 0, 2'b11, 4'd0,  0, 8'h80, 1, 5, 2, 1, 13'h300);
    add(13'h300, 0, 2'b11, 4'd1,  0, 8'h00, 0, 5, 2, 1, 13'h300);

    #12;
    chk("reset_total", 32'(total_err), 0);
    chk("reset_unm", 32'(unmapped_cnt), 0);
    chk("reset_full", 32'(table_full), 0);
    chk("reset_ccerr", 32'(cc_error), 0);
    chk("reset_epid", 32'(err_pid), 0);
    chk("reset_rd", {rd_used, 2'b00, rd_pid, 12'(rd_err)}, 0);
    reset_n = 1'b1;
    put(0, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      send_pkt(vecs[i].pid, vecs[i].tei, vecs[i].afc, vecs[i].cc, vecs[i].af_len, vecs[i].flag, 0);
      chk($sformatf("v%0d_ccerr", i), 32'(cc_error), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_total", i), 32'(total_err), 32'(vecs[i].exp_total));
      chk($sformatf("v%0d_unm", i), 32'(unmapped_cnt), 32'(vecs[i].exp_unm));
      chk($sformatf("v%0d_full", i), 32'(table_full), 32'(vecs[i].exp_full));
      chk($sformatf("v%0d_epid", i), 32'(err_pid), 32'(vecs[i].exp_epid));
    end

    rd(0); chk("rd0_pid", 32'(rd_pid), 32'h100); chk("rd0_used", 32'(rd_used), 1); chk("rd0_err", 32'(rd_err), 2);
    rd(1); chk("rd1_pid", 32'(rd_pid), 32'h200); chk("rd1_err", 32'(rd_err), 2);
    rd(2); chk("rd2_pid", 32'(rd_pid), 32'h300); chk("rd2_err", 32'(rd_err), 1);
    rd(3); chk("rd3_pid", 32'(rd_pid), 32'h400); chk("rd3_err", 32'(rd_err), 0);

    // Error on PID 0x200 (last cc 8) with clr_counters during EVAL.
    send_pkt(13'h200, 0, 2'b01, 4'd0, 0, 0, 1);
    chk("clr_total", 32'(total_err), 0);
    chk("clr_unm", 32'(unmapped_cnt), 0);
    chk("clr_full", 32'(table_full), 1);
    rd(1); chk("clr_rd1_err", 32'(rd_err), 0); chk("clr_rd1_pid", 32'(rd_pid), 32'h200);
    send_pkt(13'h200, 0, 2'b01, 4'd1, 0, 0, 0);
    chk("clr_next_ccerr", 32'(cc_error), 0);
    chk("clr_next_total", 32'(total_err), 0);

    // Sync at H3 aborts the first header; second header (PID 0x300, cc 5 after 1) errors.
    put(1, 1, 8'h47); put(1, 0, 8'h03); put(1, 0, 8'h00);
    send_pkt(13'h300, 0, 2'b01, 4'd5, 0, 0, 0);
    chk("restart_ccerr", 32'(cc_error), 1);
    chk("restart_total", 32'(total_err), 1);
    chk("restart_epid", 32'(err_pid), 32'h300);

    // Saturation: 16 errors on PID 0x100 (last cc 12).
    for (int k = 0; k < 16; k++) send_pkt(13'h100, 0, 2'b01, 4'((12 + 2 * (k + 1)) % 16), 0, 0, 0);
    chk("sat_ccerr", 32'(cc_error), 1);
    chk("sat_total", 32'(total_err), 15);
    rd(0); chk("sat_rd0_err", 32'(rd_err), 15);

    flush_table = 1'b1;
    put(0, 0, 8'h00);
    flush_table = 1'b0;
    chk("flush_full", 32'(table_full), 0);
    chk("flush_total", 32'(total_err), 0);
    rd(0); chk("flush_rd0_used", 32'(rd_used), 0);
    send_pkt(13'h600, 0, 2'b01, 4'd1, 0, 0, 0);
    send_pkt(13'h600, 0, 2'b01, 4'd3, 0, 0, 0);
    chk("flush_new_ccerr", 32'(cc_error), 1);
    chk("flush_new_total", 32'(total_err), 1);
    rd(0); chk("flush_rd0_pid", 32'(rd_pid), 32'h600); chk("flush_rd0_err", 32'(rd_err), 1);

    // Reset in the middle of a header.
    put(1, 1, 8'h47); put(1, 0, 8'h06);
    valid = 1'b1; sync = 1'b0; data = 8'h00;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_total", 32'(total_err), 0);
    chk("rst_epid", 32'(err_pid), 0);
    chk("rst_rd", {rd_used, 2'b00, rd_pid, 12'(rd_err)}, 0);
    chk("rst_full", 32'(table_full), 0);
    valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(0); chk("rst_rd0_used", 32'(rd_used), 0);
    send_pkt(13'h600, 0, 2'b01, 4'd5, 0, 0, 0);
    chk("rst_new_ccerr", 32'(cc_error), 0);
    rd(0); chk("rst_new_used", 32'(rd_used), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
